// File: rtl/rr_index_arbiter.sv
// rr_index_arbiter
//   Round-robin arbiter that picks one of N_REQ level-sensitive requesters and
//   offers its index to a downstream 3-to-8 one-hot decoder. The index is
//   offered with a valid/ready handshake. After acceptance, the winner keeps
//   ownership (HOLD) until it drops its request. The rotating priority pointer
//   moves past each completed owner, so no requester starves.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous reset, active-low
//   req        in   request vector, bit i = requester i
//   gnt_ready  in   downstream accepts the offered index
//   gnt_valid  out  gnt_idx is being offered (OFFER)
//   gnt_idx    out  registered winner index, stable from OFFER entry until IDLE
//   gnt_active out  winner owns the resource (HOLD)
//   busy       out  arbiter is not idle
//
// Every output comes from a register or is decoded from state. No path runs
// combinationally from req to an output.

module rr_index_arbiter #(
    parameter int N_REQ   = 8,
    parameter int IDX_W   = 3,
    parameter int HOLD_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             gnt_ready,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_active,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OFFER = 2'b01,
        HOLD  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q,   ptr_d;
    logic [IDX_W-1:0] idx_q,   idx_d;

    // Walk the offsets from the far end back toward ptr. The last hit is
    // therefore the first set bit in the order ptr, ptr+1, ... The index sum
    // wraps naturally because N_REQ == 2**IDX_W.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] w;
        logic [IDX_W-1:0] k;
        w = p;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = p + IDX_W'(i);
            if (r[k]) w = k;
        end
        return w;
    endfunction

    // State, pointer and index registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = OFFER;
                    idx_d   = rr_pick(req, ptr_q);
                end
            end
            OFFER: begin
                // Withdrawal takes precedence over ready. The pointer stays
                // put because no grant was completed.
                if (!req[idx_q]) begin
                    state_d = IDLE;
                end else if (gnt_ready) begin
                    if (HOLD_EN != 0) begin
                        state_d = HOLD;
                    end else begin
                        state_d = IDLE;
                        ptr_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (!req[idx_q]) begin
                    state_d = IDLE;
                    ptr_d   = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from state only
    always_comb begin
        gnt_valid  = (state_q == OFFER);
        gnt_active = (state_q == HOLD);
        busy       = (state_q == OFFER) || (state_q == HOLD);
        gnt_idx    = idx_q;
    end

endmodule
